mult_pipe: RTL and testbench
============================

Name: mult_pipe

Overview:
- Parametrised, handshaked successor to the fixed-width registered multiplier.
- Multiplies two WIDTH-bit operands with a per-transaction signed/unsigned mode and a configurable pipeline depth.
- Uses valid/ready flow control with global-stall backpressure.
- Sits in the mult datapath in place of the fixed 25x25 wrapper, e.g. as a mantissa multiplier feeding downstream rounding/normalisation.

Parameters:
- WIDTH, 25, operand width in bits (>=2).
- STAGES, 3, total register stages from operand capture to prod output (>=2): one input stage, STAGES-2 internal stages, one output stage.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
- out_valid  out  1  prod holds a valid result.
- out_ready  in  1  consumer accepts prod this cycle.
- prod  out  2*WIDTH  exact product.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (rst_n=0 at a clk edge): all stage valid bits 0; out_valid=0; prod=0; busy=0. Data registers other than prod need not be reset.
- Reset mid-operation discards all in-flight beats; no result emerges for them.
- Acceptance: a beat transfers when in_valid && in_ready at a clk edge. Output transfers when out_valid && out_ready.
- stall = out_valid && !out_ready.
- in_ready = !stall (combinational). in_valid is never used to compute in_ready.
- When stall=1, every stage (valid and data) holds.
- When stall=0, every stage advances by one; a stage whose upstream is empty loads valid=0.
- Bubbles are not collapsed; throughput is 1 beat/cycle while out_ready=1.
- Latency: a beat accepted at edge N presents on prod/out_valid after edge N+STAGES-1, i.e. STAGES cycles counting the capture edge. Each stall cycle adds one cycle.
- Arithmetic: a, b and is_signed are captured in the input stage. Each operand is extended to 2*WIDTH bits: sign extension if is_signed=1, zero extension if 0. prod is the low 2*WIDTH bits of the product, which is exact in both modes.
- Most-negative squared (signed) gives 2^(2*WIDTH-2) and fits the output width.
- The multiply sits combinationally between the input stage and the next stage. The remaining stages are plain registers, and synthesis retiming is allowed.
- is_signed travels with its own beat; a mode change between consecutive beats has no cross-effect.
- prod holds its last value while out_valid=0 after a drain. It is cleared only by reset.
- Simultaneous in_valid, out_valid and out_ready=1: accept and emit in the same cycle with no bubble.
- in_valid=1 while stall=1: not accepted, and the source must hold a/b/is_signed. Data changing under in_valid without acceptance has no effect.

Optional Feature:
- Macro: MULT_PIPE_PERF_EN.
- When defined, two extra outputs are present:
  - stall_cnt (16 bits): counts cycles with stall=1.
  - beat_cnt (16 bits): counts output transfers.
- Both counters saturate at 0xFFFF and are reset to 0 by rst_n.
- When not defined, neither port nor counter logic exists, and core behaviour is identical.

Decomposition:
- Package mult_pkg holds:
  - constant DEF_WIDTH=25;
  - constant DEF_STAGES=3;
  - a function prod_w(w) returning 2*w;
  - constant PERF_CNT_W=16.
- One natural sub-module, mult_pipe_stage: a WIDTH-generic data register plus valid bit with enable and synchronous active-low valid clear. It is instantiated STAGES times via generate.

Test Plan:
- Unsigned max, WIDTH=25, STAGES=3, out_ready=1: a=b=0x1FFFFFF, is_signed=0 -> prod=0x3FFFFFC000001, out_valid high exactly 3 cycles after acceptance.
- Signed mix: a=0x1FFFFFF (-1), b=3, is_signed=1 -> prod=0x3FFFFFFFFFFFD. Then a=0x1000000, b=1, signed -> prod=0x3FFFFFF000000. Same inputs unsigned -> 0x0000001000000.
- Back-to-back streaming: 8 beats a=i, b=i+1 (i=0..7) on consecutive cycles, out_ready=1 -> results i*(i+1) in order on 8 consecutive cycles, in_ready constantly 1.
- Backpressure: stream 4 beats, drop out_ready for 5 cycles once out_valid=1. Required: in_ready=0 and prod stable during the stall; all 4 results delivered in order, none lost or duplicated. With MULT_PIPE_PERF_EN, stall_cnt=5 and beat_cnt=4.
- Reset mid-flight: accept 2 beats, assert rst_n=0 for one edge -> out_valid=0, prod=0, busy=0 next cycle; no stale result ever appears.
- Parameter sweep: WIDTH=8, STAGES=2, signed a=b=0x80 -> prod=0x4000 after 2 cycles; randomized compare against a reference model for 1000 beats with random out_ready.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and helpers for the mult_pipe pipelined multiplier.
package mult_pkg;

    localparam int unsigned DEF_WIDTH  = 25;
    localparam int unsigned DEF_STAGES = 3;
    localparam int unsigned PERF_CNT_W = 16;

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// Operand/result handshake bundle for mult_pipe; master drives operands, slave is the multiplier.
interface mult_pipe_if
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           a;
    logic [WIDTH-1:0]           b;
    logic                       is_signed;
    logic                       out_valid;
    logic                       out_ready;
    logic [prod_w(WIDTH)-1:0]   prod;
    logic                       busy;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, prod, busy
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, prod, busy
    );

endinterface

// File: rtl/mult_pipe_stage.sv
// One pipeline register: data plus valid bit, advancing on en_i, valid cleared by synchronous reset.
module mult_pipe_stage #(
    parameter int unsigned DataW     = 8,
    parameter bit          ResetData = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [DataW-1:0] data_i,
    output logic             valid_o,
    output logic [DataW-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [DataW-1:0] data_q, data_d;

    // Data only loads with a real beat, so the register keeps its last value across bubbles.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        valid_q <= rst_ni ? valid_d : 1'b0;
        data_q  <= (!rst_ni && ResetData) ? '0 : data_d;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mult_pipe.sv
// Handshaked signed/unsigned WIDTH x WIDTH multiplier with STAGES register stages and global stall.
// Optional MULT_PIPE_PERF_EN adds saturating stall_cnt / beat_cnt outputs.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_pipe_if.slave            bus
`ifdef MULT_PIPE_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] beat_cnt
`endif
);

    localparam int unsigned PW  = prod_w(WIDTH);
    localparam int unsigned InW = 2 * WIDTH + 1;

    logic              stall;
    logic [STAGES-1:0] vld;
    logic [InW-1:0]    s0_data;
    logic [PW-1:0]     pdata [1:STAGES-1];

    logic              sgn_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [PW-1:0]     a_ext, b_ext, mul;

    assign stall         = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.prod      = pdata[STAGES-1];
    assign bus.busy      = |vld;

    // Multiply sits between the input stage and the first internal stage.
    assign {sgn_q, b_q, a_q} = s0_data;
    assign a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign b_ext = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign mul   = a_ext * b_ext;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_in
            mult_pipe_stage #(
                .DataW    (InW),
                .ResetData(1'b0)
            ) u_stage (
                .clk_i  (clk),
                .rst_ni (rst_n),
                .en_i   (~stall),
                .valid_i(bus.in_valid),
                .data_i ({bus.is_signed, bus.b, bus.a}),
                .valid_o(vld[0]),
                .data_o (s0_data)
            );
        end else begin : g_prod
            logic [PW-1:0] data_up;
            if (g == 1) begin : g_first
                assign data_up = mul;
            end else begin : g_rest
                assign data_up = pdata[g-1];
            end
            mult_pipe_stage #(
                .DataW    (PW),
                .ResetData(g == STAGES - 1)
            ) u_stage (
                .clk_i  (clk),
                .rst_ni (rst_n),
                .en_i   (~stall),
                .valid_i(vld[g-1]),
                .data_i (data_up),
                .valid_o(vld[g]),
                .data_o (pdata[g])
            );
        end
    end

`ifdef MULT_PIPE_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (bus.out_valid && bus.out_ready && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign beat_cnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: 25x25/3-stage directed tests and an 8x8/2-stage random run.
module tb_mult_pipe;

    localparam int WA = 25;
    localparam int SA = 3;
    localparam int WB = 8;
    localparam int SB = 2;

    logic clk;
    logic rst_n;

    mult_pipe_if #(.WIDTH(WA)) ifa ();
    mult_pipe_if #(.WIDTH(WB)) ifb ();

`ifdef MULT_PIPE_PERF_EN
    logic [15:0] stall_cnt_a, beat_cnt_a, stall_cnt_b, beat_cnt_b;
`endif

    mult_pipe #(.WIDTH(WA), .STAGES(SA)) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa)
`ifdef MULT_PIPE_PERF_EN
        ,
        .stall_cnt(stall_cnt_a),
        .beat_cnt (beat_cnt_a)
`endif
    );

    mult_pipe #(.WIDTH(WB), .STAGES(SB)) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb)
`ifdef MULT_PIPE_PERF_EN
        ,
        .stall_cnt(stall_cnt_b),
        .beat_cnt (beat_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Exact product reduced to 16 bits, straight from the signed/unsigned operand meaning.
    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                         input logic s);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        return 16'(sa * sb);
    endfunction

    typedef struct {
        logic [WA-1:0]   a;
        logic [WA-1:0]   b;
        logic            s;
        logic [2*WA-1:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec_a(input int idx);
        ifa.in_valid  = 1'b1;
        ifa.a         = vecs[idx].a;
        ifa.b         = vecs[idx].b;
        ifa.is_signed = vecs[idx].s;
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        ifa.a        = '0;
        ifa.b        = '0;
        for (int k = 0; k < SA - 1; k++) begin
            chk($sformatf("vec%0d_early_valid", idx), ifa.out_valid, 0);
            @(posedge clk); #1;
        end
        chk($sformatf("vec%0d_valid", idx), ifa.out_valid, 1);
        chk($sformatf("vec%0d_prod", idx), ifa.prod, vecs[idx].exp);
        @(posedge clk); #1;
        chk($sformatf("vec%0d_drain_valid", idx), ifa.out_valid, 0);
        chk($sformatf("vec%0d_prod_hold", idx), ifa.prod, vecs[idx].exp);
    endtask

    int b_beats  = 0;
    int b_stalls = 0;

    initial begin
        rst_n         = 1'b0;
        ifa.in_valid  = 1'b0; ifa.a = '0; ifa.b = '0; ifa.is_signed = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_valid  = 1'b0; ifb.a = '0; ifb.b = '0; ifb.is_signed = 1'b0; ifb.out_ready = 1'b1;

        vecs[0] = '{25'h1FFFFFF, 25'h1FFFFFF, 1'b0, 50'h3FFFFFC000001};
        vecs[1] = '{25'h1FFFFFF, 25'h0000003, 1'b1, 50'h3FFFFFFFFFFFD};
        vecs[2] = '{25'h1000000, 25'h0000001, 1'b1, 50'h3FFFFFF000000};
        vecs[3] = '{25'h1000000, 25'h0000001, 1'b0, 50'h0000001000000};
        vecs[4] = '{25'h1000000, 25'h1000000, 1'b1, 50'h1000000000000};
        vecs[5] = '{25'h1FFFFFF, 25'h1FFFFFF, 1'b1, 50'h0000000000001};
        vecs[6] = '{25'h0000000, 25'h0001234, 1'b0, 50'h0000000000000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_valid", ifa.out_valid, 0);
        chk("rst_a_prod", ifa.prod, 0);
        chk("rst_a_busy", ifa.busy, 0);
        chk("rst_a_in_ready", ifa.in_ready, 1);
        chk("rst_b_valid", ifb.out_valid, 0);
        chk("rst_b_prod", ifb.prod, 0);
`ifdef MULT_PIPE_PERF_EN
        chk("rst_a_stall_cnt", stall_cnt_a, 0);
        chk("rst_a_beat_cnt", beat_cnt_a, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single beats with exact latency
        for (int i = 0; i < 7; i++) begin
            run_vec_a(i);
        end

        // Back-to-back streaming
        ifa.out_ready = 1'b1;
        for (int c = 0; c < 8 + SA; c++) begin
            int k;
            if (c < 8) begin
                ifa.in_valid  = 1'b1;
                ifa.a         = 25'(c);
                ifa.b         = 25'(c + 1);
                ifa.is_signed = 1'b0;
                chk("stream_in_ready", ifa.in_ready, 1);
            end else begin
                ifa.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            k = c - (SA - 1);
            if (k >= 0 && k < 8) begin
                chk($sformatf("stream_valid%0d", k), ifa.out_valid, 1);
                chk($sformatf("stream_prod%0d", k), ifa.prod, 64'(k * (k + 1)));
            end else begin
                chk($sformatf("stream_idle%0d", c), ifa.out_valid, 0);
            end
        end

        // Backpressure: 4 beats, 5 stall cycles once the first result shows
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int idx, got, stall_left;
            bit started;
            logic [2*WA-1:0] held;
            idx = 0; got = 0; stall_left = 5; started = 1'b0; held = '0;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                @(posedge clk); #1;
                ifa.in_valid  = (idx < 4);
                ifa.a         = 25'(10 + idx);
                ifa.b         = 25'(20 + idx);
                ifa.is_signed = 1'b0;
                if (!started && ifa.out_valid) started = 1'b1;
                ifa.out_ready = !(started && stall_left > 0);
                #1;
                if (!ifa.out_ready) begin
                    chk("bp_in_ready", ifa.in_ready, 0);
                    chk("bp_valid_hold", ifa.out_valid, 1);
                    if (stall_left == 5) held = ifa.prod;
                    else chk("bp_prod_hold", ifa.prod, held);
                    stall_left--;
                end
                if (ifa.in_valid && ifa.in_ready) idx++;
                if (ifa.out_valid && ifa.out_ready) begin
                    chk($sformatf("bp_prod%0d", got), ifa.prod, 64'((10 + got) * (20 + got)));
                    got++;
                end
            end
            ifa.in_valid  = 1'b0;
            ifa.out_ready = 1'b1;
            chk("bp_results", got, 4);
            chk("bp_accepted", idx, 4);
            @(posedge clk); #1;
            chk("bp_drain_valid", ifa.out_valid, 0);
`ifdef MULT_PIPE_PERF_EN
            chk("bp_stall_cnt", stall_cnt_a, 5);
            chk("bp_beat_cnt", beat_cnt_a, 4);
`endif
        end

        // Reset mid-flight
        ifa.in_valid = 1'b1; ifa.a = 25'd5; ifa.b = 25'd7; ifa.is_signed = 1'b0;
        @(posedge clk); #1;
        ifa.a = 25'd6; ifa.b = 25'd8;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_valid", ifa.out_valid, 0);
        chk("midrst_prod", ifa.prod, 0);
        chk("midrst_busy", ifa.busy, 0);
`ifdef MULT_PIPE_PERF_EN
        chk("midrst_stall_cnt", stall_cnt_a, 0);
        chk("midrst_beat_cnt", beat_cnt_a, 0);
`endif
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("midrst_no_stale", ifa.out_valid, 0);
            chk("midrst_idle_busy", ifa.busy, 0);
        end

        // WIDTH=8 STAGES=2: most-negative squared
        ifb.in_valid = 1'b1; ifb.a = 8'h80; ifb.b = 8'h80; ifb.is_signed = 1'b1;
        ifb.out_ready = 1'b1;
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
        chk("w8_early_valid", ifb.out_valid, 0);
        @(posedge clk); #1;
        chk("w8_valid", ifb.out_valid, 1);
        chk("w8_prod", ifb.prod, 16'h4000);
        b_beats++;
        @(posedge clk); #1;

        // Random stream against a queue-based reference
        begin
            int acc, cyc;
            bit prev_stall;
            logic [15:0] prev_prod;
            logic [15:0] q[$];
            acc = 0; cyc = 0; prev_stall = 1'b0; prev_prod = '0;
            while ((acc < 1000 || q.size() != 0 || ifb.out_valid) && cyc < 20000) begin
                @(posedge clk); #1;
                cyc++;
                if (prev_stall) begin
                    chk("rnd_stall_valid", ifb.out_valid, 1);
                    chk("rnd_stall_prod", ifb.prod, prev_prod);
                end
                ifb.in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
                ifb.a         = 8'($urandom);
                ifb.b         = 8'($urandom);
                ifb.is_signed = 1'($urandom);
                ifb.out_ready = ($urandom_range(0, 3) != 0);
                #1;
                chk("rnd_in_ready", ifb.in_ready, !(ifb.out_valid && !ifb.out_ready));
                prev_stall = ifb.out_valid && !ifb.out_ready;
                prev_prod  = ifb.prod;
                if (prev_stall) b_stalls++;
                if (ifb.out_valid && ifb.out_ready) begin
                    b_beats++;
                    chk("rnd_expected_pending", q.size() != 0, 1);
                    if (q.size() != 0) chk("rnd_prod", ifb.prod, q.pop_front());
                end
                if (ifb.in_valid && ifb.in_ready) begin
                    q.push_back(ref8(ifb.a, ifb.b, ifb.is_signed));
                    acc++;
                end
            end
            ifb.in_valid  = 1'b0;
            ifb.out_ready = 1'b1;
            chk("rnd_accepted", acc, 1000);
            chk("rnd_drained", q.size(), 0);
            @(posedge clk); #1;
            chk("rnd_idle_busy", ifb.busy, 0);
`ifdef MULT_PIPE_PERF_EN
            chk("rnd_stall_cnt", stall_cnt_b, 64'(b_stalls));
            chk("rnd_beat_cnt", beat_cnt_b, 64'(b_beats));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
